// File: rtl/io_arb_pkg.sv
// Shared types and IO address map for the two-master IO bus arbiter.
// Consumers: io_arb_pick, io_bus_arbiter (build option IO_ARB_FIXED_PRIO_EN).
package io_arb_pkg;

  localparam int unsigned IO_ADDR_W = 8;
  localparam int unsigned IO_DATA_W = 32;
  localparam logic [IO_ADDR_W-1:0] IO_ADDR_MAX = 8'h18;

  localparam logic [IO_ADDR_W-1:0] LED_DATA = 8'h00;
  localparam logic [IO_ADDR_W-1:0] SWT_DATA = 8'h04;
  localparam logic [IO_ADDR_W-1:0] SEG_REDY = 8'h08;
  localparam logic [IO_ADDR_W-1:0] SEG_DATA = 8'h0C;
  localparam logic [IO_ADDR_W-1:0] SWX_REDY = 8'h10;
  localparam logic [IO_ADDR_W-1:0] SWX_DATA = 8'h14;
  localparam logic [IO_ADDR_W-1:0] CNT_DATA = 8'h18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  // Word-aligned and inside the decoded register window.
  function automatic logic addr_legal(input logic [IO_ADDR_W-1:0] addr,
                                      input logic [IO_ADDR_W-1:0] max_addr = IO_ADDR_MAX);
    return (addr <= max_addr) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/io_arb_pick.sv
// Combinational winner selection between the two masters.
// IO_ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
module io_arb_pick
  import io_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  output logic any_req,
  output logic win_id
);

  // Winner decode: on a tie the master not granted last wins (or m0 when fixed)
  always_comb begin
    any_req = req0 | req1;
    win_id  = 1'b0;
    if (req0 && req1) begin
`ifdef IO_ARB_FIXED_PRIO_EN
      win_id = 1'b0 & last_id;
`else
      win_id = ~last_id;
`endif
    end else if (req1) begin
      win_id = 1'b1;
    end else begin
      win_id = 1'b0;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master IO bus arbiter/sequencer: one single-cycle strobe per held request.
// Build option IO_ARB_FIXED_PRIO_EN: fixed m0 priority, no round-robin pointer.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = IO_ADDR_W,
  parameter int unsigned DATA_W = IO_DATA_W,
  parameter logic [ADDR_W-1:0] ADDR_MAX = 8'h18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_dout,
  output logic              io_we,
  output logic              io_rd,
  input  logic [DATA_W-1:0] io_din,
  output logic              busy,
  output logic              gnt_id
);

  arb_state_t        state_r;
  logic              gnt_r;
  logic [ADDR_W-1:0] io_addr_r;
  logic [DATA_W-1:0] io_dout_r;
  logic              io_we_r, io_rd_r;
  logic              m0_ack_r, m1_ack_r, m0_err_r, m1_err_r;
  logic [DATA_W-1:0] m0_rdata_r, m1_rdata_r;
  logic              last_id_s, any_req_s, win_id_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_we_s;

`ifdef IO_ARB_FIXED_PRIO_EN
  assign last_id_s = gnt_r;
`else
  logic ptr_r;
  assign last_id_s = ptr_r;
`endif

  io_arb_pick u_pick (
    .req0    (m0_req),
    .req1    (m1_req),
    .last_id (last_id_s),
    .any_req (any_req_s),
    .win_id  (win_id_s)
  );

  // Route the winning master's request fields
  always_comb begin
    if (win_id_s) begin
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
      sel_we_s    = m1_we;
    end else begin
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      sel_we_s    = m0_we;
    end
  end

  // Sequencer FSM with all bus and completion outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
`ifndef IO_ARB_FIXED_PRIO_EN
      ptr_r      <= 1'b1;
`endif
      gnt_r      <= 1'b0;
      io_addr_r  <= {ADDR_W{1'b0}};
      io_dout_r  <= {DATA_W{1'b0}};
      io_we_r    <= 1'b0;
      io_rd_r    <= 1'b0;
      m0_ack_r   <= 1'b0;
      m1_ack_r   <= 1'b0;
      m0_err_r   <= 1'b0;
      m1_err_r   <= 1'b0;
      m0_rdata_r <= {DATA_W{1'b0}};
      m1_rdata_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            gnt_r <= win_id_s;
`ifndef IO_ARB_FIXED_PRIO_EN
            ptr_r <= win_id_s;
`endif
            if (addr_legal(sel_addr_s, ADDR_MAX)) begin
              state_r   <= BUS;
              io_addr_r <= sel_addr_s;
              io_dout_r <= sel_wdata_s;
              io_we_r   <= sel_we_s;
              io_rd_r   <= ~sel_we_s;
            end else if (win_id_s) begin
              // Illegal address: complete with error, no bus cycle
              state_r    <= ACK;
              m1_ack_r   <= 1'b1;
              m1_err_r   <= 1'b1;
              m1_rdata_r <= {DATA_W{1'b0}};
            end else begin
              state_r    <= ACK;
              m0_ack_r   <= 1'b1;
              m0_err_r   <= 1'b1;
              m0_rdata_r <= {DATA_W{1'b0}};
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUS: begin
          state_r <= ACK;
          io_we_r <= 1'b0;
          io_rd_r <= 1'b0;
          if (gnt_r) begin
            m1_ack_r   <= 1'b1;
            m1_err_r   <= 1'b0;
            m1_rdata_r <= io_rd_r ? io_din : {DATA_W{1'b0}};
          end else begin
            m0_ack_r   <= 1'b1;
            m0_err_r   <= 1'b0;
            m0_rdata_r <= io_rd_r ? io_din : {DATA_W{1'b0}};
          end
        end
        ACK: begin
          state_r  <= IDLE;
          m0_ack_r <= 1'b0;
          m1_ack_r <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          io_we_r  <= 1'b0;
          io_rd_r  <= 1'b0;
          m0_ack_r <= 1'b0;
          m1_ack_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = (state_r != IDLE);
  assign gnt_id   = gnt_r;
  assign io_addr  = io_addr_r;
  assign io_dout  = io_dout_r;
  assign io_we    = io_we_r;
  assign io_rd    = io_rd_r;
  assign m0_ack   = m0_ack_r;
  assign m1_ack   = m1_ack_r;
  assign m0_err   = m0_err_r;
  assign m1_err   = m1_err_r;
  assign m0_rdata = m0_rdata_r;
  assign m1_rdata = m1_rdata_r;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter.
// Tie-order expectations follow IO_ARB_FIXED_PRIO_EN when it is defined.
module tb_io_bus_arbiter;
  import io_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [7:0]  m0_addr = 8'h00, m1_addr = 8'h00;
  logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we, io_rd;
  logic [31:0] io_din = 32'h0;
  logic        busy, gnt_id;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int we_cnt = 0;
  int base;
  logic exp_first;

  io_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd),
    .io_din(io_din), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  // Strobe pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (io_rd) rd_cnt <= rd_cnt + 1;
    if (io_we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef IO_ARB_FIXED_PRIO_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    tick();
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_gnt", {31'h0, gnt_id}, 32'h0);
    check("rst_strobes", {30'h0, io_we, io_rd}, 32'h0);
    check("rst_acks", {30'h0, m0_ack, m1_ack}, 32'h0);
    check("rst_io_addr", {24'h0, io_addr}, 32'h0);
    check("rst_io_dout", io_dout, 32'h0);
    tick();
    rst = 1'b0;

    // m0 write 0x00
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = LED_DATA; m0_wdata = 32'h0000A5A5;
    base = we_cnt;
    tick();
    check("w_strobe", {30'h0, io_we, io_rd}, 32'h2);
    check("w_addr", {24'h0, io_addr}, 32'h0);
    check("w_dout", io_dout, 32'h0000A5A5);
    check("w_busy_noack", {30'h0, busy, m0_ack}, 32'h2);
    tick();
    check("w_ack", {29'h0, m0_ack, m0_err, io_we}, 32'h4);
    m0_req = 1'b0;
    tick();
    check("w_idle", {29'h0, busy, m0_ack, io_we}, 32'h0);
    check("w_pulses", we_cnt - base, 32'd1);

    // m1 read 0x18
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = CNT_DATA; io_din = 32'h00001234;
    tick();
    check("r_strobe", {30'h0, io_we, io_rd}, 32'h1);
    check("r_addr", {24'h0, io_addr}, 32'h18);
    check("r_gnt", {31'h0, gnt_id}, 32'h1);
    tick();
    check("r_ack", {29'h0, m1_ack, m1_err, io_rd}, 32'h4);
    check("r_rdata", m1_rdata, 32'h00001234);
    check("r_m0_hold", {30'h0, m0_ack, m0_err}, 32'h0);
    check("r_m0_rdata", m0_rdata, 32'h0);
    m1_req = 1'b0;
    tick();

    // tie on 0x14 reads: last grant was m1, so m0 wins
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = SWX_DATA;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = SWX_DATA;
    io_din = 32'h0000BEEF;
    base = rd_cnt;
    tick();
    check("t1_gnt", {31'h0, gnt_id}, 32'h0);
    tick();
    check("t1_ack", {30'h0, m0_ack, m1_ack}, 32'h2);
    check("t1_rdata", m0_rdata, 32'h0000BEEF);
    m0_req = 1'b0;
    tick();
    check("t1_gap", {30'h0, busy, io_rd}, 32'h0);
    tick();
    check("t1_second", {30'h0, gnt_id, io_rd}, 32'h3);
    tick();
    check("t1_ack2", {30'h0, m0_ack, m1_ack}, 32'h1);
    check("t1_rdata2", m1_rdata, 32'h0000BEEF);
    m1_req = 1'b0;
    tick();
    check("t1_pulses", rd_cnt - base, 32'd2);

    // illegal addresses: out of range and misaligned
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h1C;
    base = rd_cnt;
    tick();
    check("il1_ack", {28'h0, m0_ack, m0_err, io_we, io_rd}, 32'hC);
    check("il1_rdata", m0_rdata, 32'h0);
    m0_req = 1'b0;
    tick();
    check("il1_idle", {31'h0, busy}, 32'h0);
    m0_req = 1'b1; m0_addr = 8'h06;
    tick();
    check("il2_ack", {28'h0, m0_ack, m0_err, io_we, io_rd}, 32'hC);
    m0_req = 1'b0;
    tick();
    check("il_pulses", rd_cnt - base, 32'd0);

    // tie after an m0 grant: round-robin picks m1 first
    m0_req = 1'b1; m0_addr = SWX_DATA;
    m1_req = 1'b1; m1_addr = SWX_DATA;
    io_din = 32'h00005A5A;
    tick();
    check("t2_first", {31'h0, gnt_id}, {31'h0, exp_first});
    tick();
    check("t2_ack", {30'h0, m0_ack, m1_ack}, exp_first ? 32'h1 : 32'h2);
    if (exp_first) m1_req = 1'b0; else m0_req = 1'b0;
    tick();
    tick();
    check("t2_second", {31'h0, gnt_id}, {31'h0, ~exp_first});
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // m0 holds req through ack: back-to-back writes
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = SEG_REDY; m0_wdata = 32'h3;
    base = we_cnt;
    tick();
    tick();
    check("h_ack1", {31'h0, m0_ack}, 32'h1);
    tick();
    check("h_idle", {31'h0, busy}, 32'h0);
    tick();
    check("h_bus2", {31'h0, io_we}, 32'h1);
    tick();
    check("h_ack2", {31'h0, m0_ack}, 32'h1);
    m0_req = 1'b0;
    tick();
    check("h_done", {31'h0, busy}, 32'h0);
    check("h_pulses", we_cnt - base, 32'd2);

    // reset during BUS aborts the transaction
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = SWT_DATA;
    tick();
    check("a_bus", {31'h0, io_rd}, 32'h1);
    rst = 1'b1;
    #1;
    check("a_abort", {28'h0, io_rd, busy, m0_ack, m1_ack}, 32'h0);
    check("a_rdata", m1_rdata, 32'h0);
    check("a_io_addr", {24'h0, io_addr}, 32'h0);
    m0_req = 1'b0;
    tick();
    rst = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = SEG_DATA; m1_wdata = 32'h77;
    tick();
    check("a_new_bus", {30'h0, gnt_id, io_we}, 32'h3);
    check("a_new_dout", io_dout, 32'h77);
    tick();
    check("a_new_ack", {29'h0, m1_ack, m1_err, m0_ack}, 32'h4);
    m1_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
